// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped UART receiver with DATA and STATUS registers.
// Receives 8N1 frames by default. Defining UART_RX_PARITY_EN turns this into
// an 8E1 receiver with a PARITY state and a live par_err flag.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle; waits for a falling edge once rx_s has been seen high
// START  | half-bit wait, then confirms the start bit (else glitch -> IDLE)
// DATA   | samples 8 data bits LSB first at bit centres
// PARITY | samples the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | samples the stop bit; loads the buffer or flags a framing error

module uart_rx_mmio #(
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          BAUD      = 115200,
  parameter logic [7:0]  ADDR_DATA = 8'hFE,
  parameter logic [7:0]  ADDR_STAT = 8'hFD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] addr,
  input  logic       rd_en,
  output logic [7:0] rdata,
  output logic       hit,
  output logic       valid
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bitn, bitn_nxt;
  logic             rx_m, rx_s;
  logic             armed;
  logic [7:0]       shift;
  logic [7:0]       rx_buf;
  logic             overrun, frame_err, par_err, par_bad;
  logic             go_start, samp_data, load, ferr_set, stop_done;
  logic             rd_data, rd_stat;

  assign rd_data = rd_en && (addr == ADDR_DATA);
  assign rd_stat = rd_en && (addr == ADDR_STAT);

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // FSM state, bit-timer and bit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bitn  <= bitn_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_set;
`endif

  // Next-state logic and one-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bitn_nxt  = bitn;
    go_start  = 1'b0;
    samp_data = 1'b0;
    load      = 1'b0;
    ferr_set  = 1'b0;
    stop_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s && armed) begin
          go_start  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            bitn_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          samp_data = 1'b1;
          if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bitn_nxt = bitn + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
          perr_set  = (rx_s != ^shift);
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          stop_done = 1'b1;
          if (rx_s) load = !par_bad;
          else      ferr_set = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // IDLE may only start a frame after it has seen the line high, so a line
  // stuck low produces a single framing error instead of a stream of them.
  always_ff @(posedge clk) begin
    if (rst)                       armed <= 1'b0;
    else if (state == IDLE && rx_s) armed <= 1'b1;
    else if (go_start)             armed <= 1'b0;
  end

  // Shift register, holding buffer and status flags; hardware sets win over
  // same-cycle read clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift     <= '0;
      rx_buf    <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (samp_data) shift[bitn] <= rx_s;
      if (rd_data) valid <= 1'b0;
      if (rd_stat) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (load) begin
        rx_buf <= shift;
        valid  <= 1'b1;
        if (valid && !rd_data) overrun <= 1'b1;
      end
      if (ferr_set) frame_err <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error flag plus a per-frame marker that blocks the load at STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      if (rd_stat)   par_err <= 1'b0;
      if (perr_set)  par_err <= 1'b1;
      if (stop_done) par_bad <= 1'b0;
      if (perr_set)  par_bad <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
  assign par_bad = 1'b0;
`endif

  // CPU-side register decode.
  always_comb begin
    hit   = (addr == ADDR_DATA) || (addr == ADDR_STAT);
    rdata = 8'h00;
    if (addr == ADDR_DATA)      rdata = rx_buf;
    else if (addr == ADDR_STAT) rdata = {4'b0, par_err, frame_err, overrun, valid};
  end

endmodule
